// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : MM:SS BCD stopwatch driven by sampled 1 Hz / 2 Hz divider ticks,
//            with run / hold / adjust modes and a wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int MAX_MIN      = 99,
  parameter bit START_PAUSED = 1'b0
) (
  input  logic       CLK_REF,
  input  logic       CLK_RES,
  input  logic       TICK_1HZ,
  input  logic       TICK_2HZ,
  input  logic       PAUSE_PULSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       PAUSED,
  output logic       ROLLOVER
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_ADJUST = 2'd2
  } mode_t;

  localparam logic [6:0] MAX_MIN_VAL = 7'(MAX_MIN);

  // Tick sample pipelines (start high so a tick already high yields no edge)
  logic t1_s1, t1_s2, t2_s1, t2_s2;
  logic ev1, ev2;

  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused;
  logic       rollover;
  mode_t      mode;

  // Incremented-field candidates
  logic [3:0] sec_tens_inc, sec_ones_inc, min_tens_inc, min_ones_inc;
  logic [6:0] min_value;
  logic       sec_wrap, min_wrap;

  assign ev1 = t1_s1 & ~t1_s2;
  assign ev2 = t2_s1 & ~t2_s2;

  // Mode is a pure function of ADJ and the current pause flag
  always_comb begin
    mode = MODE_RUN;
    if (ADJ)         mode = MODE_ADJUST;
    else if (paused) mode = MODE_HOLD;
  end

  // BCD +1 for seconds (wrap at 59) and minutes (wrap at MAX_MIN)
  always_comb begin
    sec_wrap     = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    sec_ones_inc = sec_ones + 4'd1;
    sec_tens_inc = sec_tens;
    if (sec_ones == 4'd9) begin
      sec_ones_inc = 4'd0;
      sec_tens_inc = sec_wrap ? 4'd0 : sec_tens + 4'd1;
    end

    min_value    = ({3'b000, min_tens} * 7'd10) + {3'b000, min_ones};
    min_wrap     = (min_value == MAX_MIN_VAL);
    min_ones_inc = min_ones + 4'd1;
    min_tens_inc = min_tens;
    if (min_wrap) begin
      min_ones_inc = 4'd0;
      min_tens_inc = 4'd0;
    end else if (min_ones == 4'd9) begin
      min_ones_inc = 4'd0;
      min_tens_inc = min_tens + 4'd1;
    end
  end

  // State register: tick sampling, pause flag, digit updates, wrap pulse
  always_ff @(posedge CLK_REF) begin
    if (CLK_RES) begin
      t1_s1    <= 1'b1;
      t1_s2    <= 1'b1;
      t2_s1    <= 1'b1;
      t2_s2    <= 1'b1;
      paused   <= START_PAUSED;
      rollover <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      t1_s1    <= TICK_1HZ;
      t1_s2    <= t1_s1;
      t2_s1    <= TICK_2HZ;
      t2_s2    <= t2_s1;
      paused   <= paused ^ PAUSE_PULSE;
      rollover <= 1'b0;
      case (mode)
        MODE_RUN: begin
          if (ev1) begin
            sec_tens <= sec_tens_inc;
            sec_ones <= sec_ones_inc;
            if (sec_wrap) begin
              min_tens <= min_tens_inc;
              min_ones <= min_ones_inc;
              rollover <= min_wrap;
            end
          end
        end
        MODE_ADJUST: begin
          // SEL only matters on the 2 Hz event cycle; 1 Hz events are dropped
          if (ev2) begin
            if (SEL) begin
              sec_tens <= sec_tens_inc;
              sec_ones <= sec_ones_inc;
            end else begin
              min_tens <= min_tens_inc;
              min_ones <= min_ones_inc;
            end
          end
        end
        default: begin
          // Hold: events are discarded, digits frozen
        end
      endcase
    end
  end

  assign MIN_TENS = min_tens;
  assign MIN_ONES = min_ones;
  assign SEC_TENS = sec_tens;
  assign SEC_ONES = sec_ones;
  assign PAUSED   = paused;
  assign ROLLOVER = rollover;

endmodule
`default_nettype wire
